// File: rtl/brisc_pkg.sv
// Shared definitions for the BRISC program loader.
// Provides the loader state encoding, the NOP instruction value and the
// default instruction/address widths used by the loader and its sub-module.
package brisc_pkg;

    typedef enum logic [2:0] {
        WAIT_LEN,
        RECV,
        CHECK,
        DONE,
        ERROR
    } loader_state_e;

    localparam int unsigned DEFAULT_INSTR_W = 16;
    localparam int unsigned DEFAULT_ADDR_W  = 5;
    localparam logic [31:0] NOP_INSTR       = '0;

endpackage

// File: rtl/uart_program_loader_if.sv
// Bus bundle between the program loader and its environment.
// Carries the UART byte stream (rx_valid/rx_data), the reload request,
// the fetch read port (program_counter/instruction) and load status.
//   slave  : the loader side (consumes bytes and fetch address)
//   master : the driving side (UART receiver, fetch stage, control)
interface uart_program_loader_if #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned ADDR_W  = 5
);
    logic                rx_valid;
    logic [7:0]          rx_data;
    logic                reload;
    logic [ADDR_W-1:0]   program_counter;
    logic [INSTR_W-1:0]  instruction;
    logic                load_done;
    logic                load_error;
    logic [ADDR_W:0]     words_loaded;

    modport slave (
        input  rx_valid, rx_data, reload, program_counter,
        output instruction, load_done, load_error, words_loaded
    );

    modport master (
        output rx_valid, rx_data, reload, program_counter,
        input  instruction, load_done, load_error, words_loaded
    );
endinterface

// File: rtl/loader_word_assembler.sv
// Collects bytes MSB-first into an INSTR_W-bit word.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : synchronous discard of any partial word (wins over byte_valid)
//   byte_valid  : byte_data is accepted this cycle
//   byte_data   : incoming byte
//   word_valid  : combinational, high on the cycle the final byte of a word arrives
//   word        : the completed word (valid with word_valid)
module loader_word_assembler #(
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);
    localparam int unsigned BPW   = INSTR_W / 8;
    localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [INSTR_W-1:0] asm_q, asm_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [INSTR_W+7:0] shifted;

    always_comb begin
        shifted    = {asm_q, byte_data};
        word       = shifted[INSTR_W-1:0];
        word_valid = byte_valid && !clear && (idx_q == IDX_W'(BPW - 1));
        asm_d      = asm_q;
        idx_d      = idx_q;
        if (clear) begin
            asm_d = '0;
            idx_d = '0;
        end else if (byte_valid) begin
            asm_d = shifted[INSTR_W-1:0];
            idx_d = word_valid ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q <= '0;
            idx_q <= '0;
        end else begin
            asm_q <= asm_d;
            idx_q <= idx_d;
        end
    end
endmodule

// File: rtl/uart_program_loader.sv
// Runtime-loaded instruction store for the BRISC core.
// A UART byte stream frames a load as: LEN byte N (0 => full depth, clamped
// to depth), then N words of INSTR_W/8 bytes each, MSB first. The fetch port
// returns a registered word, or NOP unless the load completed and the address
// lies inside the loaded range.
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : uart_program_loader_if.slave (rx byte stream, reload,
//              program_counter/instruction, load_done/load_error/words_loaded)
// Optional: define UART_LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte (LEN ^ all data bytes) before the load is accepted.
module uart_program_loader
    import brisc_pkg::*;
#(
    parameter int unsigned INSTR_W     = DEFAULT_INSTR_W,
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_program_loader_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    loader_state_e      state_q, state_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [ADDR_W:0]    count_inc;
    logic [31:0]        timer_q, timer_d;
    logic [INSTR_W-1:0] instruction_q, instruction_d;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic               asm_clear, asm_valid, word_valid;
    logic [INSTR_W-1:0] word;
    logic               timeout_hit;

    logic [INSTR_W-1:0] mem [DEPTH];

    loader_word_assembler #(.INSTR_W(INSTR_W)) u_asm (
        .clk        (CLK),
        .rst        (RST),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_data  (bus.rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        timer_d     = timer_q;
`ifdef UART_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        asm_clear   = 1'b1;
        asm_valid   = 1'b0;
        count_inc   = count_q + 1'b1;
        // Fires after TIMEOUT_CYC consecutive idle clocks inside a frame.
        timeout_hit = (TIMEOUT_CYC != 0) && !bus.rx_valid
                      && ((timer_q + 32'd1) >= TIMEOUT_CYC);

        if (bus.reload) begin
            state_d = WAIT_LEN;
            count_d = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                WAIT_LEN: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == 8'd0 || 32'(bus.rx_data) > DEPTH)
                            len_d = (ADDR_W+1)'(DEPTH);
                        else
                            len_d = (ADDR_W+1)'(bus.rx_data);
                        count_d = '0;
                        timer_d = '0;
`ifdef UART_LOADER_CHECKSUM_EN
                        csum_d  = bus.rx_data;
`endif
                        state_d = RECV;
                    end
                end
                RECV: begin
                    asm_clear = 1'b0;
                    asm_valid = bus.rx_valid;
                    timer_d   = bus.rx_valid ? '0 : timer_q + 32'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                    if (bus.rx_valid) csum_d = csum_q ^ bus.rx_data;
`endif
                    if (word_valid) begin
                        count_d = count_inc;
                        if (count_inc == len_q) begin
`ifdef UART_LOADER_CHECKSUM_EN
                            state_d = CHECK;
`else
                            state_d = DONE;
`endif
                        end
                    end else if (timeout_hit) begin
                        asm_clear = 1'b1;
                        state_d   = ERROR;
                    end
                end
`ifdef UART_LOADER_CHECKSUM_EN
                CHECK: begin
                    timer_d = bus.rx_valid ? '0 : timer_q + 32'd1;
                    if (bus.rx_valid)
                        state_d = (bus.rx_data == csum_q) ? DONE : ERROR;
                    else if (timeout_hit)
                        state_d = ERROR;
                end
`endif
                DONE:    ;
                ERROR:   ;
                default: state_d = ERROR;
            endcase
        end
    end

    always_comb begin
        bus.load_done    = (state_q == DONE);
        bus.load_error   = (state_q == ERROR);
        bus.words_loaded = (state_q == DONE) ? count_q : '0;
        bus.instruction  = instruction_q;
        instruction_d    = INSTR_W'(NOP_INSTR);
        if (state_q == DONE && {1'b0, bus.program_counter} < count_q)
            instruction_d = mem[bus.program_counter];
    end

    // Storage is not reset; the write address is the low bits of the word count.
    always_ff @(posedge CLK) begin
        if (word_valid)
            mem[count_q[ADDR_W-1:0]] <= word;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= WAIT_LEN;
            len_q         <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            instruction_q <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            instruction_q <= instruction_d;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// Directed test of uart_program_loader (INSTR_W=16, ADDR_W=5, TIMEOUT_CYC=100).
// Build with UART_LOADER_CHECKSUM_EN to exercise the checksum frame variant.
module tb_uart_program_loader;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [7:0] csum_acc;

    uart_program_loader_if #(.INSTR_W(16), .ADDR_W(5)) bus ();

    uart_program_loader #(.INSTR_W(16), .ADDR_W(5), .TIMEOUT_CYC(100)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge CLK);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_len(input logic [7:0] b);
        csum_acc = b;
        send_byte(b);
    endtask

    task automatic send_data(input logic [7:0] b);
        csum_acc = csum_acc ^ b;
        send_byte(b);
    endtask

    task automatic finish_frame();
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(csum_acc);
`endif
    endtask

    task automatic do_reload();
        @(negedge CLK);
        bus.reload = 1'b1;
        @(negedge CLK);
        bus.reload = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [4:0] pc, input logic [15:0] exp);
        @(negedge CLK);
        bus.program_counter = pc;
        @(negedge CLK);
        check_eq(tag, 32'(bus.instruction), 32'(exp));
    endtask

    initial begin
        bus.rx_valid        = 1'b0;
        bus.rx_data         = '0;
        bus.reload          = 1'b0;
        bus.program_counter = '0;
        csum_acc            = '0;

        // Reset state
        #2;
        check_eq("rst_done",  32'(bus.load_done), 0);
        check_eq("rst_err",   32'(bus.load_error), 0);
        check_eq("rst_words", 32'(bus.words_loaded), 0);
        check_eq("rst_instr", 32'(bus.instruction), 0);
        @(negedge CLK);
        RST = 1'b0;

        // Nominal 3-word load
        send_len(8'h03);
        send_data(8'h10); send_data(8'h50);
        send_data(8'h11); send_data(8'h4E);
        send_data(8'hF8);
        check_eq("nom_not_done", 32'(bus.load_done), 0);
        send_data(8'h04);
        finish_frame();
        check_eq("nom_done",  32'(bus.load_done), 1);
        check_eq("nom_words", 32'(bus.words_loaded), 3);
        check_eq("nom_err",   32'(bus.load_error), 0);
        read_check("nom_pc0", 5'd0, 16'h1050);
        read_check("nom_pc1", 5'd1, 16'h114E);
        read_check("nom_pc2", 5'd2, 16'hF804);
        read_check("nom_pc3", 5'd3, 16'h0000);
        read_check("nom_pc4", 5'd4, 16'h0000);

        // N=0 => full 32-word load; word i = {i, 8'h80+i}
        do_reload();
        check_eq("rl_done_clr",  32'(bus.load_done), 0);
        check_eq("rl_words_clr", 32'(bus.words_loaded), 0);
        send_len(8'h00);
        for (int i = 0; i < 32; i++) begin
            send_data(8'(i));
            send_data(8'(8'h80 + i));
        end
        finish_frame();
        check_eq("full_done",  32'(bus.load_done), 1);
        check_eq("full_words", 32'(bus.words_loaded), 32);
        read_check("full_pc31", 5'd31, 16'h1F9F);
        read_check("full_pc0",  5'd0,  16'h0080);
        // Surplus bytes in DONE are ignored
        send_byte(8'h55); send_byte(8'h55);
        check_eq("full_extra_done", 32'(bus.load_done), 1);
        read_check("full_extra_pc0", 5'd0, 16'h0080);
        read_check("full_pc17", 5'd17, 16'h1191);

        // Timeout: partial frame then silence
        do_reload();
        send_len(8'h02);
        send_data(8'h12); send_data(8'h34); send_data(8'h56);
        repeat (94) @(negedge CLK);
        check_eq("to_before", 32'(bus.load_error), 0);
        repeat (10) @(negedge CLK);
        check_eq("to_err",   32'(bus.load_error), 1);
        check_eq("to_done",  32'(bus.load_done), 0);
        check_eq("to_words", 32'(bus.words_loaded), 0);
        read_check("to_pc0", 5'd0, 16'h0000);
        read_check("to_pc1", 5'd1, 16'h0000);
        send_byte(8'h01);
        check_eq("to_sticky", 32'(bus.load_error), 1);

        // Reload coincident with a data byte drops that byte
        do_reload();
        check_eq("rl_err_clr", 32'(bus.load_error), 0);
        send_len(8'h01);
        send_data(8'hAB);
        @(negedge CLK);
        bus.reload   = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hEE;
        @(negedge CLK);
        bus.reload   = 1'b0;
        bus.rx_valid = 1'b0;
        check_eq("mid_state_clr", 32'(bus.load_done), 0);
        send_len(8'h01);
        send_data(8'hAB); send_data(8'hCD);
        finish_frame();
        check_eq("mid_done",  32'(bus.load_done), 1);
        check_eq("mid_words", 32'(bus.words_loaded), 1);
        read_check("mid_pc0", 5'd0, 16'hABCD);
        read_check("mid_pc1", 5'd1, 16'h0000);

        // Asynchronous reset between edges while in DONE
        read_check("arst_pre", 5'd0, 16'hABCD);
        #2;
        RST = 1'b1;
        #1;
        check_eq("arst_done",  32'(bus.load_done), 0);
        check_eq("arst_words", 32'(bus.words_loaded), 0);
        check_eq("arst_instr", 32'(bus.instruction), 0);
        @(negedge CLK);
        RST = 1'b0;
        send_len(8'h01);
        send_data(8'h12); send_data(8'h34);
        finish_frame();
        check_eq("arst_reload_done", 32'(bus.load_done), 1);
        read_check("arst_pc0", 5'd0, 16'h1234);

`ifdef UART_LOADER_CHECKSUM_EN
        // Explicit checksum frames: 01^12^34 = 27
        do_reload();
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        check_eq("cs_wait", 32'(bus.load_done), 0);
        send_byte(8'h27);
        check_eq("cs_good_done", 32'(bus.load_done), 1);
        check_eq("cs_good_err",  32'(bus.load_error), 0);
        do_reload();
        send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h00);
        check_eq("cs_bad_err",  32'(bus.load_error), 1);
        check_eq("cs_bad_done", 32'(bus.load_done), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
